my_chip: RTL and testbench
==========================

# my_chip

Bit-serial, microcoded 8-bit CPU core for a pin-limited tapeout slot. It has no memory of its own. It streams the program-counter address out serially, receives a 32-bit instruction serially from an external instruction memory, and decodes it. It then fetches and executes a routine of 44-bit micro-instructions, which also arrive serially from an external micro-ROM. The current FSM state is exported so the off-chip host can tell which memory to serve.

## Interface
Parameters: none. All widths are fixed constants (see Structure).
- clock  in  1  single system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- io_in  in  12  [0] instr_in: instruction bit, MSB first; [1] m_instr_in: micro-instruction bit, MSB first; [11:2] ignored
- io_out  out  12  [0] inst_addr_stream; [1] m_inst_addr_stream; [5:2] cpu_state; [11:6] tied 0

## Operation
- State encoding (cpu_state):
  - 0 SEND_PC, 1 FETCH, 2 DECODE, 3 SEND_MPC, 4 FETCH_MINST
  - 5 DECODE_MINST, 6 EXECUTE1, 7 EXECUTE2
  - 8 SET_MAR, 9 SET_MDR: reserved, never entered; any illegal state returns to SEND_PC
- Architectural state:
  - PC: 8 bits
  - mPC: 8 bits; its micro-address is sent as 9 bits, {1'b0, mPC}
  - register file: 4×8
  - micro-register bank: 19×8, indices 0..18 per the codebase mapping: A, B, ALU_RESULT, CC_GREATER, CC_EQUAL, REG_SEL, REG_WR_DATA, REG_RD_DATA, IS_IMM, IMM, REG_SRC, REG_DST, MBRANCH_TARGET, M_PC, RS1, RS2, RD, BRANCH_TARGET, IMM_INSTR
  - bank access rules: index 13 reads mPC and ignores writes; indices 19–31 read 0 and ignore writes
- Instruction fields (32 bits):
  - [31:24] micro-routine entry
  - [23:22] rd, [21:20] rs1, [19:18] rs2
  - [17] is_imm, [16] reserved
  - [15:8] imm, [7:0] branch target
- DECODE actions:
  - load RD, RS1, RS2, IS_IMM, IMM, BRANCH_TARGET; IMM_INSTR ← imm
  - mPC ← entry
  - PC ← PC+1 (8-bit wrap)
- Micro-instruction fields (44 bits):
  - [43:41] type, [40:36] srcA, [35:31] srcB, [30:26] dst
  - [25:23] aluop, [22:15] mimm, [14:7] mtarget, [6:0] reserved
- Micro-instruction types:
  - 0 MOVE: dst←bank[srcA]
  - 1 LOADI: dst←mimm
  - 2 ALU: A←bank[srcA], B←bank[srcB]; ALU_RESULT, CC_GREATER, CC_EQUAL and dst←result
  - 3 REGRD: REG_RD_DATA←rf[REG_SEL[1:0]]
  - 4 REGWR: rf[REG_SEL[1:0]]←REG_WR_DATA
  - 5 BEQ: mPC←mtarget if CC_EQUAL≠0
  - 6 BGT: mPC←mtarget if CC_GREATER≠0
  - 7 END: if mimm[0], PC←BRANCH_TARGET
- aluop: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1, 7 PASS_A.
  - All 8-bit, modulo 2^8.
  - CC_GREATER = (A>B) unsigned; CC_EQUAL = (A==B); each is stored as 8'd1 or 8'd0.
- mPC ← mPC+1 (wrap) unless a branch is taken.
- After an END micro-instruction the FSM goes to SEND_PC; after any other type it goes to SEND_MPC.

## Timing
- Reset values: state SEND_PC; all counters, PC, mPC, register file and micro-registers 0; io_out[1:0]=0.
- SEND_PC: 8 cycles.
  - io_out[0] = PC[7−k] combinationally during cycle k, so the host samples before each edge.
  - Then → FETCH.
- FETCH: 32 cycles; io_in[0] shifted in on each rising edge, MSB first. Then → DECODE.
- DECODE: 1 cycle. → SEND_MPC.
- SEND_MPC: 9 cycles; io_out[1] = {0,mPC}[8−k]. → FETCH_MINST.
- FETCH_MINST: 44 cycles; io_in[1] shifted in, MSB first. → DECODE_MINST.
- DECODE_MINST: 1 cycle; latches the fields. → EXECUTE1.
- EXECUTE1: 1 cycle; operand read, ALU and flags latched. → EXECUTE2.
- EXECUTE2: 1 cycle; destination write, regfile write, mPC/PC update.
- io_out[0] is 0 outside SEND_PC; io_out[1] is 0 outside SEND_MPC.
- Reset asserted at any point aborts immediately and returns everything to reset values.
- Shift counters wrap to 0 on each state exit.

## Structure
- Shared package `ucpu_pkg`:
  - state enum
  - micro-register index constants
  - micro-type and ALU-op enums
  - widths: PC 8, MPC 8, INST 32, MINST 44, MADDR 9, DATA 8
- One sub-module, `ucpu_alu`: combinational; A, B, op → result, gt, eq.
- The top level holds the FSM, shift registers and both register banks.

## Test plan
- Reset low then released: cpu_state=0 and io_out[0]=0 for all 8 cycles; state=1 after 8 clocks.
- Send instruction 0x0C00_0000: after 32+1 clocks state=3; the 9-bit stream is 0x00C; 44 clocks later state=5.
- Routine LOADI A←5, LOADI B←3, ALU ADD dst=ALU_RESULT, END: ALU_RESULT=8, CC_GREATER=1, CC_EQUAL=0; state returns to 0 and the next PC stream is 00000001.
- LOADI A←7, LOADI B←7, ALU SUB, BEQ mtarget=0x20: the next SEND_MPC streams 0x020.
- Instruction with branch target 0x40, END with mimm=1: the next SEND_PC streams 0x40.
- LOADI REG_SEL←2, LOADI REG_WR_DATA←0xAA, REGWR, LOADI REG_WR_DATA←0, REGRD: REG_RD_DATA=0xAA.

Source files
------------

// File: rtl/ucpu_pkg.sv
// ucpu_pkg: shared definitions for the bit-serial microcoded CPU core.
//   - FSM state encoding (exported on io_out[5:2])
//   - micro-register bank index constants
//   - micro-instruction type and ALU opcode enums
//   - micro-instruction field layout (packed struct)
//   - fixed datapath widths
package ucpu_pkg;

  localparam int PC_W    = 8;
  localparam int MPC_W   = 8;
  localparam int INST_W  = 32;
  localparam int MINST_W = 44;
  localparam int MADDR_W = 9;
  localparam int DATA_W  = 8;

  localparam int N_MREG  = 19;
  localparam int N_REG   = 4;

  typedef enum logic [3:0] {
    ST_SEND_PC      = 4'd0,
    ST_FETCH        = 4'd1,
    ST_DECODE       = 4'd2,
    ST_SEND_MPC     = 4'd3,
    ST_FETCH_MINST  = 4'd4,
    ST_DECODE_MINST = 4'd5,
    ST_EXECUTE1     = 4'd6,
    ST_EXECUTE2     = 4'd7,
    ST_SET_MAR      = 4'd8,
    ST_SET_MDR      = 4'd9
  } cpu_state_e;

  // Micro-register bank indices
  localparam logic [4:0] MR_A              = 5'd0;
  localparam logic [4:0] MR_B              = 5'd1;
  localparam logic [4:0] MR_ALU_RESULT     = 5'd2;
  localparam logic [4:0] MR_CC_GREATER     = 5'd3;
  localparam logic [4:0] MR_CC_EQUAL       = 5'd4;
  localparam logic [4:0] MR_REG_SEL        = 5'd5;
  localparam logic [4:0] MR_REG_WR_DATA    = 5'd6;
  localparam logic [4:0] MR_REG_RD_DATA    = 5'd7;
  localparam logic [4:0] MR_IS_IMM         = 5'd8;
  localparam logic [4:0] MR_IMM            = 5'd9;
  localparam logic [4:0] MR_REG_SRC        = 5'd10;
  localparam logic [4:0] MR_REG_DST        = 5'd11;
  localparam logic [4:0] MR_MBRANCH_TARGET = 5'd12;
  localparam logic [4:0] MR_M_PC           = 5'd13;
  localparam logic [4:0] MR_RS1            = 5'd14;
  localparam logic [4:0] MR_RS2            = 5'd15;
  localparam logic [4:0] MR_RD             = 5'd16;
  localparam logic [4:0] MR_BRANCH_TARGET  = 5'd17;
  localparam logic [4:0] MR_IMM_INSTR      = 5'd18;

  typedef enum logic [2:0] {
    MT_MOVE  = 3'd0,
    MT_LOADI = 3'd1,
    MT_ALU   = 3'd2,
    MT_REGRD = 3'd3,
    MT_REGWR = 3'd4,
    MT_BEQ   = 3'd5,
    MT_BGT   = 3'd6,
    MT_END   = 3'd7
  } mtype_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_SHL1   = 3'd5,
    ALU_SHR1   = 3'd6,
    ALU_PASS_A = 3'd7
  } alu_op_e;

  // 44-bit micro-instruction, MSB first
  typedef struct packed {
    mtype_e      mtype;    // [43:41]
    logic [4:0]  src_a;    // [40:36]
    logic [4:0]  src_b;    // [35:31]
    logic [4:0]  dst;      // [30:26]
    alu_op_e     aluop;    // [25:23]
    logic [7:0]  mimm;     // [22:15]
    logic [7:0]  mtarget;  // [14:7]
    logic [6:0]  rsvd;     // [6:0]
  } minst_t;

  // Condition flags live in the bank as full bytes (1 or 0)
  function automatic logic [DATA_W-1:0] flag8(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/ucpu_alu.sv
// ucpu_alu: combinational 8-bit ALU for the microcoded core.
// Ports:
//   i_a, i_b   : operands
//   i_op       : operation select (alu_op_e)
//   o_result   : 8-bit result, modulo 2^8
//   o_gt       : unsigned i_a > i_b
//   o_eq       : i_a == i_b
module ucpu_alu
  import ucpu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_e           i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_gt,
  output logic              o_eq
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:    o_result = i_a + i_b;
      ALU_SUB:    o_result = i_a - i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_OR:     o_result = i_a | i_b;
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_SHL1:   o_result = {i_a[DATA_W-2:0], 1'b0};
      ALU_SHR1:   o_result = {1'b0, i_a[DATA_W-1:1]};
      ALU_PASS_A: o_result = i_a;
      default:    o_result = '0;
    endcase
  end

  assign o_gt = (i_a > i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/my_chip.sv
// my_chip: bit-serial microcoded 8-bit CPU core with off-chip instruction
// memory and micro-ROM.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   io_in  : [0] instruction bit in (MSB first), [1] micro-instruction bit
//            in (MSB first), [11:2] unused
//   io_out : [0] PC address stream, [1] micro-address stream,
//            [5:2] current FSM state, [11:6] zero
module my_chip
  import ucpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  cpu_state_e          r_state;
  cpu_state_e          w_state_next;
  logic [5:0]          r_cnt;
  logic                w_cnt_last;
  logic                w_shifting;

  logic [PC_W-1:0]     r_pc;
  logic [MPC_W-1:0]    r_mpc;
  logic [INST_W-1:0]   r_inst;
  logic [MINST_W-1:0]  r_minst;
  minst_t              r_uop;
  logic [DATA_W-1:0]   r_wval;

  logic [DATA_W-1:0]   r_mreg [0:N_MREG-1];
  logic [DATA_W-1:0]   r_rf   [0:N_REG-1];

  logic [N_MREG-1:0]   w_mreg_we;
  logic [DATA_W-1:0]   w_mreg_wd [0:N_MREG-1];

  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_gt;
  logic                w_alu_eq;
  logic                w_branch_taken;

  logic [MADDR_W-1:0]  w_maddr;
  logic [3:0]          w_maddr_idx;
  logic                w_pc_bit;
  logic                w_maddr_bit;
  logic                w_unused_bits;

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_SEND_PC;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_cnt_last = 1'b0;
    w_shifting = 1'b0;
    case (r_state)
      ST_SEND_PC:     begin w_shifting = 1'b1; w_cnt_last = (r_cnt == 6'd7);  end
      ST_FETCH:       begin w_shifting = 1'b1; w_cnt_last = (r_cnt == 6'd31); end
      ST_SEND_MPC:    begin w_shifting = 1'b1; w_cnt_last = (r_cnt == 6'd8);  end
      ST_FETCH_MINST: begin w_shifting = 1'b1; w_cnt_last = (r_cnt == 6'd43); end
      default:        begin w_shifting = 1'b0; w_cnt_last = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SEND_PC:      if (w_cnt_last) w_state_next = ST_FETCH;
      ST_FETCH:        if (w_cnt_last) w_state_next = ST_DECODE;
      ST_DECODE:       w_state_next = ST_SEND_MPC;
      ST_SEND_MPC:     if (w_cnt_last) w_state_next = ST_FETCH_MINST;
      ST_FETCH_MINST:  if (w_cnt_last) w_state_next = ST_DECODE_MINST;
      ST_DECODE_MINST: w_state_next = ST_EXECUTE1;
      ST_EXECUTE1:     w_state_next = ST_EXECUTE2;
      ST_EXECUTE2:     w_state_next = (r_uop.mtype == MT_END) ? ST_SEND_PC : ST_SEND_MPC;
      default:         w_state_next = ST_SEND_PC;  // reserved/illegal states recover
    endcase
  end

  // Bit counter for the four serial phases; cleared on every phase exit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       r_cnt <= '0;
    else if (w_cnt_last || !w_shifting) r_cnt <= '0;
    else                              r_cnt <= r_cnt + 6'd1;
  end

  // ---------------- Bank reads ----------------
  // Index 13 aliases the live mPC; indices past the bank read as zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    if (r_uop.src_a == MR_M_PC)           w_rd_a = r_mpc;
    else if (r_uop.src_a < 5'(N_MREG))    w_rd_a = r_mreg[r_uop.src_a];
    if (r_uop.src_b == MR_M_PC)           w_rd_b = r_mpc;
    else if (r_uop.src_b < 5'(N_MREG))    w_rd_b = r_mreg[r_uop.src_b];
  end

  ucpu_alu u_alu (
    .i_a      (w_rd_a),
    .i_b      (w_rd_b),
    .i_op     (r_uop.aluop),
    .o_result (w_alu_result),
    .o_gt     (w_alu_gt),
    .o_eq     (w_alu_eq)
  );

  assign w_branch_taken = ((r_uop.mtype == MT_BEQ) && (r_mreg[MR_CC_EQUAL]   != '0)) ||
                          ((r_uop.mtype == MT_BGT) && (r_mreg[MR_CC_GREATER] != '0));

  // ---------------- Bank writes ----------------
  always_comb begin
    w_mreg_we = '0;
    for (int i = 0; i < N_MREG; i++) w_mreg_wd[i] = '0;
    case (r_state)
      ST_DECODE: begin
        w_mreg_we[MR_RD]            = 1'b1; w_mreg_wd[MR_RD]            = {6'd0, r_inst[23:22]};
        w_mreg_we[MR_RS1]           = 1'b1; w_mreg_wd[MR_RS1]           = {6'd0, r_inst[21:20]};
        w_mreg_we[MR_RS2]           = 1'b1; w_mreg_wd[MR_RS2]           = {6'd0, r_inst[19:18]};
        w_mreg_we[MR_IS_IMM]        = 1'b1; w_mreg_wd[MR_IS_IMM]        = flag8(r_inst[17]);
        w_mreg_we[MR_IMM]           = 1'b1; w_mreg_wd[MR_IMM]           = r_inst[15:8];
        w_mreg_we[MR_BRANCH_TARGET] = 1'b1; w_mreg_wd[MR_BRANCH_TARGET] = r_inst[7:0];
        w_mreg_we[MR_IMM_INSTR]     = 1'b1; w_mreg_wd[MR_IMM_INSTR]     = r_inst[15:8];
      end
      ST_EXECUTE1: begin
        if (r_uop.mtype == MT_ALU) begin
          w_mreg_we[MR_A]          = 1'b1; w_mreg_wd[MR_A]          = w_rd_a;
          w_mreg_we[MR_B]          = 1'b1; w_mreg_wd[MR_B]          = w_rd_b;
          w_mreg_we[MR_ALU_RESULT] = 1'b1; w_mreg_wd[MR_ALU_RESULT] = w_alu_result;
          w_mreg_we[MR_CC_GREATER] = 1'b1; w_mreg_wd[MR_CC_GREATER] = flag8(w_alu_gt);
          w_mreg_we[MR_CC_EQUAL]   = 1'b1; w_mreg_wd[MR_CC_EQUAL]   = flag8(w_alu_eq);
        end
      end
      ST_EXECUTE2: begin
        // Destination write lands after the ALU side effects, so dst may
        // legitimately overwrite A/B/flags.
        if (((r_uop.mtype == MT_MOVE) || (r_uop.mtype == MT_LOADI) || (r_uop.mtype == MT_ALU))
            && (r_uop.dst < 5'(N_MREG))) begin
          w_mreg_we[r_uop.dst] = 1'b1;
          w_mreg_wd[r_uop.dst] = r_wval;
        end
        if (r_uop.mtype == MT_REGRD) begin
          w_mreg_we[MR_REG_RD_DATA] = 1'b1;
          w_mreg_wd[MR_REG_RD_DATA] = r_rf[r_mreg[MR_REG_SEL][1:0]];
        end
      end
      default: ;
    endcase
    w_mreg_we[MR_M_PC] = 1'b0;  // mPC alias is read-only
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_MREG; i++) r_mreg[i] <= '0;
    end else begin
      for (int i = 0; i < N_MREG; i++)
        if (w_mreg_we[i]) r_mreg[i] <= w_mreg_wd[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REG; i++) r_rf[i] <= '0;
    end else if ((r_state == ST_EXECUTE2) && (r_uop.mtype == MT_REGWR)) begin
      r_rf[r_mreg[MR_REG_SEL][1:0]] <= r_mreg[MR_REG_WR_DATA];
    end
  end

  // ---------------- Datapath sequencing ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_mpc   <= '0;
      r_inst  <= '0;
      r_minst <= '0;
      r_uop   <= '0;
      r_wval  <= '0;
    end else begin
      case (r_state)
        ST_FETCH:        r_inst  <= {r_inst[INST_W-2:0], io_in[0]};
        ST_DECODE: begin
          r_mpc <= r_inst[31:24];
          r_pc  <= r_pc + 8'd1;
        end
        ST_FETCH_MINST:  r_minst <= {r_minst[MINST_W-2:0], io_in[1]};
        ST_DECODE_MINST: r_uop   <= minst_t'(r_minst);
        ST_EXECUTE1: begin
          case (r_uop.mtype)
            MT_MOVE:  r_wval <= w_rd_a;
            MT_LOADI: r_wval <= r_uop.mimm;
            MT_ALU:   r_wval <= w_alu_result;
            default:  r_wval <= r_wval;
          endcase
        end
        ST_EXECUTE2: begin
          r_mpc <= w_branch_taken ? r_uop.mtarget : (r_mpc + 8'd1);
          if ((r_uop.mtype == MT_END) && r_uop.mimm[0])
            r_pc <= r_mreg[MR_BRANCH_TARGET];
        end
        default: ;
      endcase
    end
  end

  // ---------------- Serial address outputs ----------------
  // PC bit (7-k) during cycle k: for a 3-bit count 7-k equals ~k.
  assign w_pc_bit    = r_pc[~r_cnt[2:0]];
  assign w_maddr     = {1'b0, r_mpc};
  assign w_maddr_idx = 4'd8 - r_cnt[3:0];
  assign w_maddr_bit = w_maddr[w_maddr_idx];

  assign io_out = {6'd0,
                   4'(r_state),
                   (r_state == ST_SEND_MPC) & w_maddr_bit,
                   (r_state == ST_SEND_PC)  & w_pc_bit};

  assign w_unused_bits = &{1'b0, io_in[11:2], r_inst[16], r_uop.rsvd};

endmodule

// File: tb/tb_my_chip.sv
// tb_my_chip: acts as the off-chip host (instruction memory and micro-ROM)
// and checks the core against an instruction-level behavioural model.
module tb_my_chip;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] io_in = 12'd0;
  logic [11:0] io_out;

  my_chip dut (
    .clock  (clock),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [43:0] mrom [0:255];

  // Behavioural model state
  logic [7:0] m_bank [0:18];
  logic [7:0] m_rf   [0:3];
  logic [7:0] m_pc;
  logic [7:0] m_mpc;

  logic [7:0] g_pc_seen;
  logic [8:0] g_mpc_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] mi(input int t, input int sa, input int sb, input int d,
                                     input int op, input int imm, input int tgt);
    return {t[2:0], sa[4:0], sb[4:0], d[4:0], op[2:0], imm[7:0], tgt[7:0], 7'd0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 19; i++) m_bank[i] = 8'd0;
    for (int i = 0; i < 4; i++)  m_rf[i]   = 8'd0;
    m_pc  = 8'd0;
    m_mpc = 8'd0;
  endtask

  function automatic int m_read(input int idx);
    if (idx == 13) return int'(m_mpc);
    if (idx >= 19) return 0;
    return int'(m_bank[idx]);
  endfunction

  task automatic m_write(input int idx, input int v);
    if (idx < 19 && idx != 13) m_bank[idx] = 8'(v);
  endtask

  task automatic model_decode(input logic [31:0] inst);
    m_bank[16] = {6'd0, inst[23:22]};
    m_bank[14] = {6'd0, inst[21:20]};
    m_bank[15] = {6'd0, inst[19:18]};
    m_bank[8]  = {7'd0, inst[17]};
    m_bank[9]  = inst[15:8];
    m_bank[18] = inst[15:8];
    m_bank[17] = inst[7:0];
    m_mpc      = inst[31:24];
    m_pc       = 8'((int'(m_pc) + 1) % 256);
  endtask

  task automatic model_exec(input logic [43:0] w, output bit is_end);
    int t, sa, sb, d, op, imm, tgt, a, b, r;
    bit taken;
    t   = int'(w[43:41]); sa  = int'(w[40:36]); sb = int'(w[35:31]);
    d   = int'(w[30:26]); op  = int'(w[25:23]);
    imm = int'(w[22:15]); tgt = int'(w[14:7]);
    taken  = 1'b0;
    is_end = 1'b0;
    case (t)
      0: m_write(d, m_read(sa));
      1: m_write(d, imm);
      2: begin
        a = m_read(sa);
        b = m_read(sb);
        case (op)
          0: r = (a + b) % 256;
          1: r = (a - b + 256) % 256;
          2: r = a & b;
          3: r = a | b;
          4: r = a ^ b;
          5: r = (a * 2) % 256;
          6: r = a / 2;
          default: r = a;
        endcase
        m_bank[0] = 8'(a);
        m_bank[1] = 8'(b);
        m_bank[2] = 8'(r);
        m_bank[3] = (a > b)  ? 8'd1 : 8'd0;
        m_bank[4] = (a == b) ? 8'd1 : 8'd0;
        m_write(d, r);
      end
      3: m_bank[7] = m_rf[int'(m_bank[5]) % 4];
      4: m_rf[int'(m_bank[5]) % 4] = m_bank[6];
      5: taken = (m_bank[4] != 8'd0);
      6: taken = (m_bank[3] != 8'd0);
      default: begin
        is_end = 1'b1;
        if (imm % 2 == 1) m_pc = m_bank[17];
      end
    endcase
    m_mpc = taken ? 8'(tgt) : 8'((int'(m_mpc) + 1) % 256);
  endtask

  task automatic cmp_model();
    int idx;
    idx = -1;
    for (int i = 0; i < 19; i++)
      if (dut.r_mreg[i] !== m_bank[i] && idx < 0) idx = i;
    if (idx < 0) idx = 0;
    chk($sformatf("mreg[%0d]", idx), 64'(dut.r_mreg[idx]), 64'(m_bank[idx]));
    idx = -1;
    for (int i = 0; i < 4; i++)
      if (dut.r_rf[i] !== m_rf[i] && idx < 0) idx = i;
    if (idx < 0) idx = 0;
    chk($sformatf("rf[%0d]", idx), 64'(dut.r_rf[idx]), 64'(m_rf[idx]));
  endtask

  // Serve one instruction and its whole micro-routine, checking every phase.
  task automatic do_instr(input logic [31:0] inst);
    bit bad, is_end, done;
    logic [43:0] w;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (io_out[5:2] !== 4'd0 || io_out[1] !== 1'b0) bad = 1'b1;
      g_pc_seen[7-k] = io_out[0];
    end
    chk("send_pc_phase", 64'(bad), 64'd0);
    chk("pc_stream", 64'(g_pc_seen), 64'(m_pc));
    bad = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      if (io_out[5:2] !== 4'd1 || io_out[1:0] !== 2'd0) bad = 1'b1;
      io_in[0] = inst[31-k];
    end
    chk("fetch_phase", 64'(bad), 64'd0);
    @(negedge clock);
    chk("decode_state", 64'(io_out[5:2]), 64'd2);
    io_in[0] = 1'b0;
    model_decode(inst);
    done = 1'b0;
    for (int step = 0; step < 64 && !done; step++) begin
      bad = 1'b0;
      for (int k = 0; k < 9; k++) begin
        @(negedge clock);
        if (io_out[5:2] !== 4'd3 || io_out[0] !== 1'b0) bad = 1'b1;
        g_mpc_seen[8-k] = io_out[1];
      end
      chk("send_mpc_phase", 64'(bad), 64'd0);
      chk("mpc_stream", 64'(g_mpc_seen), 64'({1'b0, m_mpc}));
      w = mrom[m_mpc];
      bad = 1'b0;
      for (int k = 0; k < 44; k++) begin
        @(negedge clock);
        if (io_out[5:2] !== 4'd4 || io_out[1:0] !== 2'd0) bad = 1'b1;
        io_in[1] = w[43-k];
      end
      chk("fetch_minst_phase", 64'(bad), 64'd0);
      bad = 1'b0;
      @(negedge clock); if (io_out[5:2] !== 4'd5) bad = 1'b1;
      io_in[1] = 1'b0;
      @(negedge clock); if (io_out[5:2] !== 4'd6) bad = 1'b1;
      @(negedge clock); if (io_out[5:2] !== 4'd7) bad = 1'b1;
      chk("exec_phases", 64'(bad), 64'd0);
      model_exec(w, is_end);
      @(posedge clock); #1;
      cmp_model();
      chk("next_state", 64'(io_out[5:2]), is_end ? 64'd0 : 64'd3);
      done = is_end;
    end
    chk("routine_ended", 64'(done), 64'd1);
  endtask

  // Random routine: body of non-END types with forward-only branches, then END.
  task automatic gen_routine(input int base, input int len);
    for (int j = 0; j < len - 1; j++) begin
      mrom[base + j] = mi($urandom_range(0, 6), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 255),
                          base + $urandom_range(j + 1, len - 1));
    end
    mrom[base + len - 1] = mi(7, 0, 0, 0, 0, $urandom_range(0, 255), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] inst;
    for (int i = 0; i < 256; i++) mrom[i] = mi(7, 0, 0, 0, 0, 0, 0);
    // ADD routine
    mrom[8'h0C] = mi(1, 0, 0, 0, 0, 5, 0);
    mrom[8'h0D] = mi(1, 0, 0, 1, 0, 3, 0);
    mrom[8'h0E] = mi(2, 0, 1, 2, 0, 0, 0);
    mrom[8'h0F] = mi(7, 0, 0, 0, 0, 0, 0);
    // SUB + BEQ routine
    mrom[8'h30] = mi(1, 0, 0, 0, 0, 7, 0);
    mrom[8'h31] = mi(1, 0, 0, 1, 0, 7, 0);
    mrom[8'h32] = mi(2, 0, 1, 2, 1, 0, 0);
    mrom[8'h33] = mi(5, 0, 0, 0, 0, 0, 8'h20);
    mrom[8'h20] = mi(7, 0, 0, 0, 0, 0, 0);
    // END with PC branch
    mrom[8'h50] = mi(7, 0, 0, 0, 0, 1, 0);
    // register file round trip
    mrom[8'h60] = mi(1, 0, 0, 5, 0, 2, 0);
    mrom[8'h61] = mi(1, 0, 0, 6, 0, 8'hAA, 0);
    mrom[8'h62] = mi(4, 0, 0, 0, 0, 0, 0);
    mrom[8'h63] = mi(1, 0, 0, 6, 0, 0, 0);
    mrom[8'h64] = mi(3, 0, 0, 0, 0, 0, 0);
    mrom[8'h65] = mi(7, 0, 0, 0, 0, 0, 0);

    model_reset();
    reset = 1'b0;
    #12;
    chk("reset_io_out", 64'(io_out), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    do_instr(32'h0C00_0000);
    chk("alu_result", 64'(dut.r_mreg[2]), 64'd8);
    chk("cc_greater", 64'(dut.r_mreg[3]), 64'd1);
    chk("cc_equal",   64'(dut.r_mreg[4]), 64'd0);

    do_instr(32'h3000_0000);
    chk("pc_after_first", 64'(g_pc_seen), 64'd1);
    chk("beq_target_stream", 64'(g_mpc_seen), 64'h020);

    do_instr(32'h5000_0040);
    do_instr(32'h6000_0000);
    chk("pc_after_end_branch", 64'(g_pc_seen), 64'h40);
    chk("reg_rd_data", 64'(dut.r_mreg[7]), 64'hAA);
    chk("rf2", 64'(dut.r_rf[2]), 64'hAA);

    // Abort mid-fetch with asynchronous reset
    repeat (20) @(negedge clock);
    io_in[0] = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("abort_io_out", 64'(io_out), 64'd0);
    model_reset();
    cmp_model();
    chk("abort_pc", 64'(dut.r_pc), 64'd0);
    io_in = 12'd0;
    @(posedge clock); #1;
    reset = 1'b1;

    for (int n = 0; n < 25; n++) begin
      int base, len;
      base = $urandom_range(112, 240);
      len  = $urandom_range(2, 8);
      gen_routine(base, len);
      inst = {8'(base), 24'($urandom)};
      do_instr(inst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
